trace_commit_arbiter: RTL and testbench
=======================================

// Module: trace_commit_arbiter
// PURPOSE
//  Funnels NUM_LANES retirement ports of the superscalar core into one ordered trace record stream for the testbench tracer.
//  Compacts each cycle's valid lanes in lane order (lane 0 = oldest), buffers them in a circular FIFO and drains one record per cycle.
//  Sits between the core's commit stage and the trace writer; simulation/debug only, no architectural effect.
// PARAMETERS
//  NUM_LANES  3   commit lanes per cycle (1..4)
//  DEPTH      16  FIFO entries; power of 2, >= 2*NUM_LANES
//  EDGE_MODE  0   1: trace_valid_o is forced low for one cycle after every record, so each record gives a fresh rising edge; trace_ready_i is ignored
// PORTS
//  clk_i            in   1                   clock
//  reset_i          in   1                   synchronous, active-high reset
//  commit_valid_i   in   NUM_LANES           per-lane retire valid; any mask pattern is legal
//  commit_rec_i     in   NUM_LANES*REC_W     per-lane trace_rec_t, lane 0 in the LSBs
//  commit_ready_o   out  1                   all lanes may be accepted this cycle
//  trace_valid_o    out  1                   output record valid
//  trace_ready_i    in   1                   downstream accepts the record
//  trace_rec_o      out  REC_W               head record
//  ovf_count_o      out  32                  commit cycles lost to overflow
// BEHAVIOUR
//  - Reset: FIFO empty, rd/wr pointers 0, count 0, trace_valid_o=0, trace_rec_o=0, ovf_count_o=0, commit_ready_o=1.
//  - Reset mid-operation discards all buffered records; no partial record is ever emitted.
//  - commit_ready_o = (DEPTH - count) >= NUM_LANES, using the registered count; a same-cycle pop does not count as free space.
//  - Push: when commit_ready_o=1, n_push = popcount(commit_valid_i).
//    - Valid lanes are written to wr_ptr, wr_ptr+1, ... in ascending lane order, skipping invalid lanes.
//    - All indices wrap mod DEPTH.
//  - Pop: the FIFO head is registered into trace_rec_o.
//    - Handshake mode (EDGE_MODE=0): a record transfers on trace_valid_o & trace_ready_i.
//    - trace_valid_o and trace_rec_o hold stable while valid and not ready.
//    - Latency: a record pushed in cycle N is visible on trace_*_o in cycle N+1 at the earliest.
//  - EDGE_MODE=1: FSM IDLE -> SHOW (valid=1, one cycle) -> GAP (valid=0, one cycle) -> SHOW if FIFO non-empty, else IDLE.
//    - The pop occurs on entry to SHOW.
//    - Peak drain is 1 record per 2 cycles.
//  - Simultaneous push and pop: count_next = count + n_push - pop.
//    - count stays within 0..DEPTH; an assertion fires on violation.
//  - Empty FIFO: trace_valid_o=0 and trace_rec_o holds its last value.
//  - commit_valid_i != 0 while commit_ready_o = 0: all lanes of that cycle are dropped and the overflow path runs (see CONFIGURATION).
//  - The FIFO never reorders records; output order is cycle order, then lane order.
// CONFIGURATION
//  TRACE_OVF_CNT_EN defined:
//   - ovf_count_o increments (saturating at 32'hFFFF_FFFF) on each dropped cycle.
//   - A $display warning is printed once per overflow burst.
//  TRACE_OVF_CNT_EN undefined:
//   - ovf_count_o is tied to 0 and no counter logic exists.
//   - A dropped cycle triggers $error, because the core is expected to stall retirement on commit_ready_o.
// STRUCTURE
//  trace_pkg:
//   - typedef struct packed trace_rec_t {pc[31:0], instr[31:0], rd[4:0], rd_data[31:0], is_load, is_store, is_float, mem_size[1:0], mem_addr[31:0], mem_data[31:0], fflags[4:0]}.
//   - localparam REC_W = $bits(trace_rec_t) (=175).
//   - Edge-mode FSM state enum {IDLE, SHOW, GAP}.
//  Sub-module trace_mw_fifo: NUM_LANES-write / 1-read circular buffer with a popcount compaction network.
//  Top level: handshake or edge FSM plus the overflow counter.
// TESTING
//  1. Reset, then lane0 only valid with pc=0x80000000 -> trace_rec_o.pc=0x80000000 next cycle, trace_valid_o=1 for exactly one handshake.
//  2. Mask 3'b101 with pc A=0x100, C=0x108 -> output order 0x100 then 0x108; count returns to 0.
//  3. Hold trace_ready_i=0 while pushing 3 lanes/cycle -> commit_ready_o drops once count=14 (DEPTH-count<3); trace_rec_o stays stable.
//  4. Full-rate push of 1 lane/cycle with a simultaneous pop -> count stays constant, no drops, pointers wrap past 15 correctly.
//  5. EDGE_MODE=1 with 4 records queued -> valid pattern 1,0,1,0,1,0,1,0 over 8 cycles, then IDLE.
//  6. Force a commit while commit_ready_o=0 with TRACE_OVF_CNT_EN defined -> ovf_count_o=1, FIFO contents unchanged; reset_i mid-drain -> trace_valid_o=0 next cycle, count=0.

Source files
------------

// File: rtl/trace_commit_arbiter_pkg.sv
// ============================================================================
// Module   : trace_commit_arbiter_pkg
// Purpose  : Shared types for the trace commit arbiter: the per-instruction
//            trace record, its flattened width and the edge-mode FSM states.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package trace_commit_arbiter_pkg;

  // One retired instruction as seen by the tracer; the field order fixes the
  // bit layout on the flat commit_rec_i bus.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic        is_load;
    logic        is_store;
    logic        is_float;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [4:0]  fflags;
  } trace_rec_t;

  localparam int REC_W = $bits(trace_rec_t);

  // Edge-mode output sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } edge_state_e;

endpackage : trace_commit_arbiter_pkg

`default_nettype wire

// File: rtl/trace_commit_arbiter_if.sv
// ============================================================================
// Module   : trace_commit_arbiter_if
// Purpose  : Bundles the commit-side and trace-side signals of the arbiter.
//            master : core commit stage + trace writer (drives commits/ready)
//            slave  : trace_commit_arbiter
// Signals  : commit_valid_i  per-lane retire valid
//            commit_rec_i    per-lane records, lane 0 in the LSBs
//            commit_ready_o  all lanes may be accepted this cycle
//            trace_valid_o   output record valid
//            trace_ready_i   downstream accepts the record
//            trace_rec_o     head record
//            ovf_count_o     commit cycles lost to overflow
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface trace_commit_arbiter_if
  import trace_commit_arbiter_pkg::*;
#(
  parameter int NUM_LANES = 3
);

  logic [NUM_LANES-1:0]       commit_valid_i;
  logic [NUM_LANES*REC_W-1:0] commit_rec_i;
  logic                       commit_ready_o;
  logic                       trace_valid_o;
  logic                       trace_ready_i;
  trace_rec_t                 trace_rec_o;
  logic [31:0]                ovf_count_o;

  modport master (
    output commit_valid_i,
    output commit_rec_i,
    output trace_ready_i,
    input  commit_ready_o,
    input  trace_valid_o,
    input  trace_rec_o,
    input  ovf_count_o
  );

  modport slave (
    input  commit_valid_i,
    input  commit_rec_i,
    input  trace_ready_i,
    output commit_ready_o,
    output trace_valid_o,
    output trace_rec_o,
    output ovf_count_o
  );

endinterface : trace_commit_arbiter_if

`default_nettype wire

// File: rtl/trace_commit_arbiter_mw_fifo.sv
// ============================================================================
// Module   : trace_commit_arbiter_mw_fifo
// Purpose  : NUM_LANES-write / 1-read circular buffer. Valid lanes are
//            compacted in lane order onto consecutive slots starting at the
//            write pointer. When the buffer is empty the head is taken
//            straight from the lowest valid incoming lane so a record can
//            leave in the same cycle it arrives.
// Ports    : clk_i, reset_i  clock / synchronous active-high reset
//            push_en_i       accept this cycle's valid lanes
//            valid_i, rec_i  per-lane valid and flat records
//            pop_i           consume the head (only when avail_o)
//            avail_o         a head record exists this cycle
//            head_o          head record
//            count_o         registered occupancy
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_commit_arbiter_mw_fifo
  import trace_commit_arbiter_pkg::*;
#(
  parameter int NUM_LANES = 3,
  parameter int DEPTH     = 16
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           push_en_i,
  input  logic [NUM_LANES-1:0]           valid_i,
  input  logic [NUM_LANES*REC_W-1:0]     rec_i,
  input  logic                           pop_i,
  output logic                           avail_o,
  output trace_rec_t                     head_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  trace_rec_t             mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W:0]         count_d;

  trace_rec_t             lane_rec [NUM_LANES];
  logic [NUM_LANES-1:0]   wr_en;
  logic [PTR_W-1:0]       wr_idx [NUM_LANES];
  logic [CNT_W-1:0]       n_push;
  trace_rec_t             first_rec;

  genvar gl;
  generate
    for (gl = 0; gl < NUM_LANES; gl++) begin : g_lane
      assign lane_rec[gl] = rec_i[gl*REC_W +: REC_W];
      assign wr_en[gl]    = push_en_i & valid_i[gl];
    end
  endgenerate

  // Compaction: each valid lane lands at wr_ptr + (number of valid lanes
  // below it), which is the running popcount.
  always_comb begin
    n_push    = '0;
    first_rec = '0;
    for (int l = NUM_LANES-1; l >= 0; l--) begin
      if (wr_en[l]) first_rec = lane_rec[l];
    end
    for (int l = 0; l < NUM_LANES; l++) begin
      wr_idx[l] = wr_ptr_q + PTR_W'(n_push);
      n_push    = n_push + CNT_W'(wr_en[l]);
    end
  end

  assign avail_o = (count_q != '0) || (n_push != '0);
  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : first_rec;
  assign count_o = count_q;

  // One bit wider so an out-of-range result is visible to the check below.
  assign count_d = {1'b0, count_q} + {1'b0, n_push} - (CNT_W+1)'(pop_i);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(n_push);
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop_i);
      count_q  <= count_d[CNT_W-1:0];
    end
  end

  // Storage carries no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < NUM_LANES; l++) begin
      if (wr_en[l]) mem_q[wr_idx[l]] <= lane_rec[l];
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (count_d <= (CNT_W+1)'(DEPTH))
        else $error("trace fifo occupancy out of range: %0d", count_d);
    end
  end
`endif

endmodule : trace_commit_arbiter_mw_fifo

`default_nettype wire

// File: rtl/trace_commit_arbiter.sv
// ============================================================================
// Module   : trace_commit_arbiter
// Purpose  : Funnels NUM_LANES retirement ports into one ordered trace record
//            stream. Records are compacted into a circular FIFO and drained
//            one per cycle (EDGE_MODE=0, valid/ready handshake) or one per two
//            cycles with a forced low gap after each record (EDGE_MODE=1,
//            trace_ready_i ignored). Simulation/debug only.
// Ports    : clk_i    clock
//            reset_i  synchronous, active-high reset
//            bus      trace_commit_arbiter_if.slave (commit + trace sides)
// Config   : TRACE_OVF_CNT_EN - when defined, dropped commit cycles are
//            counted on ovf_count_o (saturating) with one warning per burst;
//            otherwise ovf_count_o is 0 and a dropped cycle is an error.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_commit_arbiter
  import trace_commit_arbiter_pkg::*;
#(
  parameter int NUM_LANES = 3,
  parameter int DEPTH     = 16,
  parameter int EDGE_MODE = 0
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  trace_commit_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_avail;
  trace_rec_t       fifo_head;
  logic             w_pop;
  logic             w_commit_ready;
  logic             w_drop;

  // Registered occupancy only: a pop in this cycle does not free a slot.
  assign w_commit_ready     = (fifo_count <= CNT_W'(DEPTH - NUM_LANES));
  assign w_drop             = (|bus.commit_valid_i) & ~w_commit_ready;
  assign bus.commit_ready_o = w_commit_ready;

  trace_commit_arbiter_mw_fifo #(
    .NUM_LANES (NUM_LANES),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .push_en_i (w_commit_ready),
    .valid_i   (bus.commit_valid_i),
    .rec_i     (bus.commit_rec_i),
    .pop_i     (w_pop),
    .avail_o   (fifo_avail),
    .head_o    (fifo_head),
    .count_o   (fifo_count)
  );

  generate
    if (EDGE_MODE != 0) begin : g_edge
      edge_state_e state_q;
      logic        valid_q;
      trace_rec_t  rec_q;
      logic        w_unused_ready;

      assign w_unused_ready = bus.trace_ready_i;
      // Pop happens on the transition into SHOW.
      assign w_pop = (state_q != SHOW) && fifo_avail;

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          rec_q   <= '0;
        end else begin
          unique case (state_q)
            SHOW: begin
              state_q <= GAP;
              valid_q <= 1'b0;
            end
            IDLE, GAP: begin
              if (fifo_avail) begin
                state_q <= SHOW;
                valid_q <= 1'b1;
                rec_q   <= fifo_head;
              end else begin
                state_q <= IDLE;
                valid_q <= 1'b0;
              end
            end
            default: begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end
          endcase
        end
      end

      assign bus.trace_valid_o = valid_q;
      assign bus.trace_rec_o   = rec_q;
    end else begin : g_handshake
      logic       valid_q;
      trace_rec_t rec_q;
      logic       w_load;

      // Output slot can take a new record when empty or being consumed.
      assign w_load = ~valid_q | bus.trace_ready_i;
      assign w_pop  = w_load & fifo_avail;

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          valid_q <= 1'b0;
          rec_q   <= '0;
        end else if (w_load) begin
          valid_q <= fifo_avail;
          if (fifo_avail) rec_q <= fifo_head;
        end
      end

      assign bus.trace_valid_o = valid_q;
      assign bus.trace_rec_o   = rec_q;
    end
  endgenerate

`ifdef TRACE_OVF_CNT_EN
  logic [31:0] ovf_q;
  logic        in_burst_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ovf_q      <= '0;
      in_burst_q <= 1'b0;
    end else begin
      in_burst_q <= w_drop;
      if (w_drop && (ovf_q != 32'hFFFF_FFFF)) ovf_q <= ovf_q + 32'd1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i && w_drop && !in_burst_q)
      $display("WARNING: %m trace overflow, commit cycles dropped at %0t", $time);
  end
`endif

  assign bus.ovf_count_o = ovf_q;
`else
  assign bus.ovf_count_o = '0;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i && w_drop)
      $error("%m commit while commit_ready_o=0: trace records lost");
  end
`endif
`endif

endmodule : trace_commit_arbiter

`default_nettype wire

// File: tb/tb_trace_commit_arbiter.sv
// ============================================================================
// Module   : tb_trace_commit_arbiter
// Purpose  : Self-checking bench for trace_commit_arbiter. One instance in
//            handshake mode, one in edge mode; a queue-based model predicts
//            outputs every cycle, plus literal expectations for directed cases.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trace_commit_arbiter;
  import trace_commit_arbiter_pkg::*;

  localparam int NL    = 3;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trace_commit_arbiter_if #(.NUM_LANES(NL)) bus0 ();
  trace_commit_arbiter_if #(.NUM_LANES(NL)) bus1 ();

  trace_commit_arbiter #(.NUM_LANES(NL), .DEPTH(DEPTH), .EDGE_MODE(0)) dut0 (
    .clk_i (clk), .reset_i (rst), .bus (bus0)
  );
  trace_commit_arbiter #(.NUM_LANES(NL), .DEPTH(DEPTH), .EDGE_MODE(1)) dut1 (
    .clk_i (clk), .reset_i (rst), .bus (bus1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic trace_rec_t mk(input logic [31:0] pc);
    trace_rec_t r;
    r.pc       = pc;
    r.instr    = pc ^ 32'hA5A5_5A5A;
    r.rd       = pc[6:2];
    r.rd_data  = ~pc;
    r.is_load  = pc[2];
    r.is_store = pc[3];
    r.is_float = pc[4];
    r.mem_size = pc[3:2];
    r.mem_addr = pc + 32'h40;
    r.mem_data = {pc[15:0], pc[31:16]};
    r.fflags   = pc[8:4];
    return r;
  endfunction

  // ---------------- reference model ----------------
  trace_rec_t  q0[$];
  trace_rec_t  q1[$];
  logic        ev0 = 1'b0, ev1 = 1'b0;
  trace_rec_t  er0 = '0, er1 = '0;
  logic [31:0] eovf0 = '0, eovf1 = '0;
  bit          armed = 0;

  always @(posedge clk) begin
    if (rst) begin
      q0.delete(); q1.delete();
      ev0 = 1'b0; ev1 = 1'b0; er0 = '0; er1 = '0; eovf0 = '0; eovf1 = '0;
    end else begin
      // handshake instance: accept all lanes if room for a full cycle
      if ((DEPTH - q0.size()) >= NL) begin
        for (int l = 0; l < NL; l++)
          if (bus0.commit_valid_i[l]) q0.push_back(trace_rec_t'(bus0.commit_rec_i[l*REC_W +: REC_W]));
      end else if (bus0.commit_valid_i != '0) begin
`ifdef TRACE_OVF_CNT_EN
        if (eovf0 != 32'hFFFF_FFFF) eovf0 = eovf0 + 1;
`endif
      end
      if (!ev0 || bus0.trace_ready_i) begin
        if (q0.size() > 0) begin er0 = q0.pop_front(); ev0 = 1'b1; end
        else ev0 = 1'b0;
      end
      // edge instance: a shown record is always followed by a low cycle
      if ((DEPTH - q1.size()) >= NL) begin
        for (int l = 0; l < NL; l++)
          if (bus1.commit_valid_i[l]) q1.push_back(trace_rec_t'(bus1.commit_rec_i[l*REC_W +: REC_W]));
      end else if (bus1.commit_valid_i != '0) begin
`ifdef TRACE_OVF_CNT_EN
        if (eovf1 != 32'hFFFF_FFFF) eovf1 = eovf1 + 1;
`endif
      end
      if (ev1) ev1 = 1'b0;
      else if (q1.size() > 0) begin er1 = q1.pop_front(); ev1 = 1'b1; end
    end
    armed = 1;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("m0_valid", bus0.trace_valid_o, ev0);
      chk("m0_rec",   bus0.trace_rec_o, er0);
      chk("m0_ready", bus0.commit_ready_o, (DEPTH - q0.size()) >= NL);
      chk("m0_ovf",   bus0.ovf_count_o, eovf0);
      chk("m1_valid", bus1.trace_valid_o, ev1);
      chk("m1_rec",   bus1.trace_rec_o, er1);
      chk("m1_ready", bus1.commit_ready_o, (DEPTH - q1.size()) >= NL);
      chk("m1_ovf",   bus1.ovf_count_o, eovf1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive0(input logic [2:0] mask, input logic [31:0] p0, p1, p2);
    bus0.commit_valid_i = mask;
    bus0.commit_rec_i   = {mk(p2), mk(p1), mk(p0)};
  endtask

  task automatic drive1(input logic [2:0] mask, input logic [31:0] p0, p1, p2);
    bus1.commit_valid_i = mask;
    bus1.commit_rec_i   = {mk(p2), mk(p1), mk(p0)};
  endtask

  initial begin
    logic [9:0] pat;
    drive0(3'b000, 0, 0, 0);
    drive1(3'b000, 0, 0, 0);
    bus0.trace_ready_i = 1'b1;
    bus1.trace_ready_i = 1'b0;
    rst = 1'b1;
    step(); step();
    chk("rst_valid", bus0.trace_valid_o, 1'b0);
    chk("rst_rec",   bus0.trace_rec_o, '0);
    chk("rst_ready", bus0.commit_ready_o, 1'b1);
    chk("rst_ovf",   bus0.ovf_count_o, 32'd0);
    rst = 1'b0;

    // single lane, next-cycle visibility, exactly one handshake
    drive0(3'b001, 32'h8000_0000, 0, 0); step();
    chk("t1_valid", bus0.trace_valid_o, 1'b1);
    chk("t1_pc",    bus0.trace_rec_o.pc, 32'h8000_0000);
    drive0(3'b000, 0, 0, 0); step();
    chk("t1_one_hs", bus0.trace_valid_o, 1'b0);
    chk("t1_hold",   bus0.trace_rec_o.pc, 32'h8000_0000);

    // sparse mask keeps lane order
    drive0(3'b101, 32'h100, 32'h104, 32'h108); step();
    chk("t2_first", bus0.trace_rec_o.pc, 32'h100);
    drive0(3'b000, 0, 0, 0); step();
    chk("t2_second", bus0.trace_rec_o.pc, 32'h108);
    step();
    chk("t2_empty", bus0.trace_valid_o, 1'b0);

    // backpressure fill: ready falls once count reaches 14
    bus0.trace_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive0(3'b111, 32'h1000 + 12*k, 32'h1004 + 12*k, 32'h1008 + 12*k); step();
      if (k == 3) chk("t3_ready_at11", bus0.commit_ready_o, 1'b1);
    end
    drive0(3'b000, 0, 0, 0);
    chk("t3_ready_drop", bus0.commit_ready_o, 1'b0);
    chk("t3_hold_pc",    bus0.trace_rec_o.pc, 32'h1000);
    step(); step();
    chk("t3_still_pc",   bus0.trace_rec_o.pc, 32'h1000);
    bus0.trace_ready_i = 1'b1; step();
    chk("t3_next_pc",    bus0.trace_rec_o.pc, 32'h1004);
    repeat (16) step();

    // steady push 1 / pop 1 with 5 buffered, pointers wrap several times
    bus0.trace_ready_i = 1'b0;
    drive0(3'b111, 32'h2000, 32'h2004, 32'h2008); step();
    drive0(3'b111, 32'h200C, 32'h2010, 32'h2014); step();
    bus0.trace_ready_i = 1'b1;
    for (int k = 0; k < 40; k++) begin
      drive0(3'b001, 32'h2018 + 4*k, 0, 0); step();
      chk("t4_pc", bus0.trace_rec_o.pc, 32'h2004 + 4*k);
    end
    drive0(3'b000, 0, 0, 0);
    repeat (8) step();
    chk("t4_drained", bus0.trace_valid_o, 1'b0);

    // all masks with intermittent ready, never committing while not ready
    for (int k = 0; k < 60; k++) begin
      bus0.trace_ready_i = (k % 3 != 0);
      if (bus0.commit_ready_o)
        drive0(3'(k % 8), 32'h3000 + 16*k, 32'h3004 + 16*k, 32'h3008 + 16*k);
      else
        drive0(3'b000, 0, 0, 0);
      step();
    end
    drive0(3'b000, 0, 0, 0);
    bus0.trace_ready_i = 1'b1;
    repeat (20) step();

`ifdef TRACE_OVF_CNT_EN
    // overflow: dropped cycle counted, buffer contents untouched
    bus0.trace_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive0(3'b111, 32'h5000 + 12*k, 32'h5004 + 12*k, 32'h5008 + 12*k); step();
    end
    chk("t6_not_ready", bus0.commit_ready_o, 1'b0);
    drive0(3'b111, 32'hDEAD_0000, 32'hDEAD_0004, 32'hDEAD_0008); step();
    chk("t6_ovf", bus0.ovf_count_o, 32'd1);
    drive0(3'b000, 0, 0, 0); step();
    chk("t6_ovf_hold", bus0.ovf_count_o, 32'd1);
    chk("t6_head",     bus0.trace_rec_o.pc, 32'h5000);
    bus0.trace_ready_i = 1'b1;
    repeat (18) step();
`endif

    // reset while records are pending
    bus0.trace_ready_i = 1'b0;
    drive0(3'b111, 32'h4000, 32'h4004, 32'h4008); step();
    drive0(3'b111, 32'h400C, 32'h4010, 32'h4014); step();
    drive0(3'b000, 0, 0, 0);
    chk("t7_busy", bus0.trace_valid_o, 1'b1);
    rst = 1'b1; step();
    chk("t7_rst_valid", bus0.trace_valid_o, 1'b0);
    chk("t7_rst_rec",   bus0.trace_rec_o, '0);
    rst = 1'b0;
    bus0.trace_ready_i = 1'b1; step(); step();
    chk("t7_stay_empty", bus0.trace_valid_o, 1'b0);
    chk("t7_ready",      bus0.commit_ready_o, 1'b1);

    // edge mode: 4 records give 1,0,1,0,1,0,1,0 then idle (ready held low)
    pat = 10'b0001010101;
    drive1(3'b111, 32'h6000, 32'h6004, 32'h6008); step();
    chk("t5_v0",  bus1.trace_valid_o, 1'b1);
    chk("t5_pc0", bus1.trace_rec_o.pc, 32'h6000);
    drive1(3'b001, 32'h600C, 0, 0); step();
    chk("t5_v1",  bus1.trace_valid_o, 1'b0);
    drive1(3'b000, 0, 0, 0);
    for (int i = 2; i < 10; i++) begin
      step();
      chk("t5_pattern", bus1.trace_valid_o, pat[i]);
      if (pat[i]) chk("t5_pc", bus1.trace_rec_o.pc, 32'h6000 + 2*i);
    end

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_trace_commit_arbiter

`default_nettype wire
